// File: rtl/regfile_multiport_pkg.sv
// Shared constants for the register file: stack address and init-FSM state encodings.
// The REGFILE_BYPASS_EN macro is consumed by regfile_multiport.sv; none is needed here.
`ifndef STACK_ADDRESS
`define STACK_ADDRESS 32'h0000_8000
`endif
`ifndef S_INIT
`define S_INIT 1'b0
`endif
`ifndef S_RUN
`define S_RUN 1'b1
`endif

package regfile_multiport_pkg;

    typedef enum logic {
        S_INIT = `S_INIT,
        S_RUN  = `S_RUN
    } rf_state_e;

    localparam logic [31:0] STACK_ADDR_DEFAULT = `STACK_ADDRESS;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset sweep sequencer: writes every entry once (SP_INIT at SP_INDEX, 0 elsewhere),
// then holds o_ready high until the next reset.
module regfile_init_seq
    import regfile_multiport_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 32,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = '0,
    parameter int              ADDR_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic [XLEN-1:0]   o_init_data,
    output logic              o_ready
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_init_we   = 1'b0;
        o_init_addr = cnt_q;
        o_init_data = '0;
        if (state_q == S_INIT) begin
            o_init_we = 1'b1;
            if (cnt_q == ADDR_W'(SP_INDEX))
                o_init_data = SP_INIT;
            cnt_d = cnt_q + 1'b1;
            // Last entry written on this edge: switch to run so ready rises with it.
            if (cnt_q == ADDR_W'(DEPTH - 1))
                state_d = S_RUN;
        end
    end

    assign o_ready = (state_q == S_RUN);

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with x0 hardwired to zero and a post-reset init sweep.
// Define REGFILE_BYPASS_EN for write-first same-cycle read/write; default is read-first.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 32,
    parameter int              NUM_RD   = 2,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = XLEN'(`STACK_ADDRESS),
    localparam int             ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*XLEN-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_valid,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_w_addr,
    input  logic [XLEN-1:0]          i_w_data,
    output logic                     o_ready
);

    logic [XLEN-1:0]   regs_q [DEPTH];
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [XLEN-1:0]   init_data;
    logic              ready;
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [XLEN-1:0]   arr_data;

    regfile_init_seq #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .SP_INDEX (SP_INDEX),
        .SP_INIT  (SP_INIT),
        .ADDR_W   (ADDR_W)
    ) u_init_seq (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_init_we   (init_we),
        .o_init_addr (init_addr),
        .o_init_data (init_data),
        .o_ready     (ready)
    );

    // User writes only count once the sweep is done; writes to x0 are dropped.
    assign user_we  = ready && i_we && (i_w_addr != '0);
    assign arr_we   = i_rst && (init_we || user_we);
    assign arr_addr = ready ? i_w_addr : init_addr;
    assign arr_data = ready ? i_w_data : init_data;

    always_ff @(posedge i_clk) begin
        if (arr_we)
            regs_q[arr_addr] <= arr_data;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   val;
        logic [XLEN-1:0]   data_q;
        logic              vld_q;

        assign addr = i_rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (user_we && (i_w_addr == addr))
                val = i_w_data;
`endif
            if (addr == '0)
                val = '0;
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= ready && i_rd_en[k];
                if (ready && i_rd_en[k])
                    data_q <= val;
            end
        end

        assign o_rd_data[k*XLEN +: XLEN] = data_q;
        assign o_rd_valid[k]             = vld_q;
    end

    assign o_ready = ready;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized bench for regfile_multiport against an array-based reference model.
`ifndef STACK_ADDRESS
`define STACK_ADDRESS 32'h0000_8000
`endif

module tb_regfile_multiport;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 32;
    localparam int NUM_RD   = 2;
    localparam int SP_INDEX = 2;
    localparam int AW       = 5;
    localparam logic [31:0] SP = `STACK_ADDRESS;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic [NUM_RD-1:0]     i_rd_en;
    logic [NUM_RD*AW-1:0]  i_rd_addr;
    logic [NUM_RD*XLEN-1:0] o_rd_data;
    logic [NUM_RD-1:0]     o_rd_valid;
    logic                  i_we;
    logic [AW-1:0]         i_w_addr;
    logic [XLEN-1:0]       i_w_data;
    logic                  o_ready;

    regfile_multiport #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .SP_INDEX (SP_INDEX)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_we       (i_we),
        .i_w_addr   (i_w_addr),
        .i_w_data   (i_w_data),
        .o_ready    (o_ready)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem [DEPTH];
    logic [31:0] exp_data [NUM_RD];
    logic        exp_vld [NUM_RD];
    logic        m_ready = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pd(input int k);
        return o_rd_data[k*XLEN +: XLEN];
    endfunction

    function automatic int ra(input int k);
        return int'(i_rd_addr[k*AW +: AW]);
    endfunction

    task automatic idle();
        i_we      = 1'b0;
        i_w_addr  = '0;
        i_w_data  = '0;
        i_rd_en   = '0;
        i_rd_addr = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        i_rd_en[k] = 1'b1;
        i_rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int a, input logic [31:0] d);
        i_we     = 1'b1;
        i_w_addr = AW'(a);
        i_w_data = d;
    endtask

    // Predict the effect of the coming edge from the current inputs, clock it, then compare.
    task automatic tick();
        int a;
        if (!i_rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int k = 0; k < NUM_RD; k++) begin
                exp_vld[k]  = 1'b0;
                exp_data[k] = '0;
            end
        end else if (!m_ready) begin
            for (int k = 0; k < NUM_RD; k++) exp_vld[k] = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) mem[i] = '0;
                mem[SP_INDEX] = SP;
            end
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                exp_vld[k] = i_rd_en[k];
                if (i_rd_en[k]) begin
                    a = ra(k);
                    if (a == 0)
                        exp_data[k] = '0;
                    else if (BYP && i_we && int'(i_w_addr) == a)
                        exp_data[k] = i_w_data;
                    else
                        exp_data[k] = mem[a];
                end
            end
            if (i_we && i_w_addr != '0) mem[i_w_addr] = i_w_data;
        end
        @(posedge i_clk);
        #1;
        chk("ready", {31'b0, o_ready}, {31'b0, m_ready});
        for (int k = 0; k < NUM_RD; k++) begin
            chk($sformatf("valid%0d", k), {31'b0, o_rd_valid[k]}, {31'b0, exp_vld[k]});
            chk($sformatf("data%0d", k), pd(k), exp_data[k]);
        end
    endtask

    initial begin
        idle();
        i_rst = 1'b0;
        tick();
        tick();
        chk("rst_data0", pd(0), 32'h0);
        chk("rst_valid", {30'b0, o_rd_valid}, 32'h0);

        // Partial sweep, then a one-cycle reset must restart it from zero.
        i_rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;

        // Full sweep with write/read attempts that must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(9, 32'hAA);
            i_rd_en   = 2'b11;
            i_rd_addr = AW*NUM_RD'($urandom);
            tick();
            chk("sweep_ready", {31'b0, o_ready}, {31'b0, (i == DEPTH - 1)});
            chk("sweep_valid", {30'b0, o_rd_valid}, 32'h0);
        end

        idle();
        set_rd(0, 9);
        set_rd(1, 2);
        tick();
        chk("init_addr9", pd(0), 32'h0);
        chk("init_sp", pd(1), SP);
        idle();
        set_rd(0, 1);
        set_rd(1, 31);
        tick();
        chk("init_addr1", pd(0), 32'h0);
        chk("init_addr31", pd(1), 32'h0);

        idle();
        set_wr(5, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(0, 5);
        tick();
        chk("rd5", pd(0), 32'hDEADBEEF);
        chk("rd5_vld", {31'b0, o_rd_valid[0]}, 32'h1);
        idle();
        tick();
        chk("rd5_hold", pd(0), 32'hDEADBEEF);
        chk("rd5_drop", {31'b0, o_rd_valid[0]}, 32'h0);

        set_wr(0, 32'h12345678);
        tick();
        idle();
        set_rd(0, 0);
        set_rd(1, 0);
        tick();
        chk("x0_p0", pd(0), 32'h0);
        chk("x0_p1", pd(1), 32'h0);

        idle();
        set_wr(7, 32'h11);
        tick();
        set_wr(7, 32'h22);
        set_rd(0, 7);
        set_rd(1, 7);
        tick();
        chk("hazard_p0", pd(0), BYP ? 32'h22 : 32'h11);
        chk("hazard_p1", pd(1), BYP ? 32'h22 : 32'h11);
        idle();
        set_rd(0, 7);
        tick();
        chk("hazard_next", pd(0), 32'h22);

        // Same-cycle write to x0 with a read of x0 stays zero in both modes.
        set_wr(0, 32'hFFFF_FFFF);
        set_rd(1, 0);
        tick();
        chk("x0_same", pd(1), 32'h0);

        for (int i = 0; i < 400; i++) begin
            i_we     = ($urandom_range(0, 2) != 0);
            i_w_addr = AW'($urandom_range(0, 7));
            i_w_data = $urandom;
            i_rd_en  = NUM_RD'($urandom);
            for (int k = 0; k < NUM_RD; k++)
                i_rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? i_w_addr : AW'($urandom_range(0, 7));
            tick();
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the core's integer register file. Provides NUM_RD synchronous read ports and one synchronous write port, with register 0 hardwired to zero. A stack-pointer register is preset to a configurable value. After reset, a built-in sequencer sweeps every entry to its initial value and then raises o_ready. Sits between decode (reads) and writeback (writes) in the pipeline.

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers (power of two, >= 4)
NUM_RD, 2, number of read ports (1..4)
SP_INDEX, 2, index of the stack-pointer register
SP_INIT, `STACK_ADDRESS, value loaded into SP_INDEX during init
ADDR_W (localparam), $clog2(DEPTH), address width

Ports:
i_clk  in  1  clock; all state changes on its rising edge
i_rst  in  1  synchronous reset, active-low
i_rd_en  in  NUM_RD  per-port read enable
i_rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
o_rd_data  out  NUM_RD*XLEN  packed read data, registered
o_rd_valid  out  NUM_RD  per-port data-valid, registered
i_we  in  1  write enable
i_w_addr  in  ADDR_W  write address
i_w_data  in  XLEN  write data
o_ready  out  1  high once the init sweep is complete

Behaviour:
- Reset: i_rst==0 at a clock edge forces state to S_INIT and clears init counter cnt to 0. Also forces o_ready=0, o_rd_data=0 and o_rd_valid=0. Array contents are not cleared by reset itself.
- FSM has two states, S_INIT and S_RUN.
- In S_INIT:
  - Each cycle writes reg[cnt] with SP_INIT if cnt==SP_INDEX, otherwise 0. Then cnt increments.
  - When cnt==DEPTH-1 is written, the FSM moves to S_RUN and o_ready rises on that same edge. Total is exactly DEPTH cycles from reset release.
- While in S_INIT:
  - i_we is ignored (write dropped).
  - Reads are ignored: o_rd_valid stays 0.
- Reset asserted mid-sweep restarts the sweep at cnt=0.
- In S_RUN, writes:
  - i_we=1 writes i_w_data to reg[i_w_addr] at the edge.
  - A write to address 0 is discarded; reg 0 always reads 0.
- In S_RUN, reads:
  - Read latency is 1 cycle. If i_rd_en[k]=1 at edge N, then o_rd_data[k] holds reg[i_rd_addr[k]] and o_rd_valid[k]=1 after edge N.
  - If i_rd_en[k]=0, o_rd_valid[k] drops to 0 and o_rd_data[k] holds its previous value.
- Simultaneous read and write to the same nonzero address in the same cycle is governed by the Optional Feature.
- Any number of read ports may address the same register; each returns the same value.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-first. A read whose address equals the write address in the same cycle (i_we=1, address nonzero) returns i_w_data.
- Undefined: read-first. The read returns the pre-write content, and the new value is visible one cycle later.
- Address 0 returns 0 in both modes.

Decomposition:
- constants.vh (shared) holds STACK_ADDRESS, plus the FSM state encodings S_INIT=1'b0 and S_RUN=1'b1 as `define constants, so that decode and test code share them.
- One sub-module, regfile_init_seq, contains the FSM and cnt. It outputs init_we, init_addr, init_data and ready. The top muxes init writes and user writes onto the single array write port.

Test Plan:
- Reset sweep: hold i_rst=0 for 2 cycles, then release → o_ready=0 for exactly 32 cycles, then 1. Reading addr 2 returns 32'h`STACK_ADDRESS, and reading addrs 1 and 31 return 0.
- Basic write/read: write 0xDEADBEEF to addr 5, then next cycle read addr 5 on port 0 → one cycle later o_rd_data[0]=0xDEADBEEF and o_rd_valid[0]=1.
- x0 protection: write 0x12345678 to addr 0, then read addr 0 on both ports → both return 0.
- Same-cycle hazard: reg 7 holds 0x11, then in one cycle write 0x22 to addr 7 and read addr 7 → returns 0x22 with REGFILE_BYPASS_EN, or 0x11 without it. A read on the next cycle returns 0x22 in both builds.
- Reset mid-sweep: assert i_rst=0 at cycle 10 of the sweep for 1 cycle → o_ready rises exactly 32 cycles after the second release.
- Writes/reads during init: drive i_we=1 to addr 9 with 0xAA and i_rd_en=2'b11 during S_INIT → o_rd_valid stays 0, and after o_ready addr 9 reads 0.
